putc_uart_tx: RTL

//  Consumer end of the CU putc interface: buffers characters strobed on putc/putc_char
//  and serialises them as 8N1 UART frames on tx. Sits between the control unit and the

---
 rtl/putc_uart_tx_pkg.sv | 22 ++
 rtl/putc_uart_tx_char_fifo.sv | 62 ++++++
 rtl/putc_uart_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/putc_uart_tx_pkg.sv
// Shared types and helpers for the putc UART transmitter.
//   tx_state_t     : serialiser states
//   RAM_BYTE       : width of one character on the CU putc interface
//   UART_DATA_BITS : data bits per 8N1 frame
//   clks_per_bit() : system clocks per UART bit (integer division)
package putc_uart_tx_pkg;

  localparam int RAM_BYTE       = 8;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/putc_uart_tx_char_fifo.sv
// Synchronous show-ahead character FIFO (reusable on the receive side).
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   push,din : write din when push && !full
//   pop,dout : dout always shows the head; pop advances it when !empty
//   full, empty, count : decoded from the registered occupancy count
module char_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("char_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/putc_uart_tx.sv
// putc_uart_tx: buffers characters strobed by the control unit and sends
// them as 8N1 UART frames.
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   putc      : one-cycle strobe, push putc_char
//   putc_char : character to send
//   full      : buffer holds FIFO_DEPTH chars, CU must hold off
//   idle      : buffer empty and serialiser idle
//   overrun   : sticky, a putc arrived while full and was dropped
//   tx        : registered UART line, idle high
module putc_uart_tx
  import putc_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                putc,
  input  logic [RAM_BYTE-1:0] putc_char,
  output logic                full,
  output logic                idle,
  output logic                overrun,
  output logic                tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("putc_uart_tx: CLK_FREQ/BAUD must be >= 2");
  end

  tx_state_t                  state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [2:0]                 bit_idx, bit_idx_nxt;
  logic [UART_DATA_BITS-1:0]  shift, shift_nxt;
  logic                       tx_nxt;
  logic                       pop;
  logic                       fifo_empty;
  logic [RAM_BYTE-1:0]        fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  char_fifo #(
    .DATA_W (RAM_BYTE),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (putc),
    .din   (putc_char),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign idle = (fifo_count == '0) && (state == TX_IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          cnt_nxt   = CNT_TOP;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (cnt == '0) begin
          cnt_nxt     = CNT_TOP;
          bit_idx_nxt = '0;
          state_nxt   = TX_DATA;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt == '0) begin
          cnt_nxt   = CNT_TOP;
          shift_nxt = shift >> 1;
          if (bit_idx == LAST_BIT) begin
            state_nxt = TX_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt == '0) begin
          state_nxt = TX_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // tx is computed from the next state so the line flop changes on the same
  // edge as the state it represents.
  always_comb begin
    case (state_nxt)
      TX_START: tx_nxt = 1'b0;
      TX_DATA:  tx_nxt = shift_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      tx      <= tx_nxt;
      if (putc && full) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

endmodule
